// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v raster counters, and
// registered sync/blank outputs aligned with the pixel coordinates.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          pixel_tick,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_end,
    output logic          frame_end
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_STOP  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_STOP  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0] div;
    logic [CW-1:0] h_next, v_next;
    logic          h_wrap;

    // Reset gating keeps the tick low during reset even when CLK_DIV=1.
    assign pixel_tick = enable && !reset && (div == DIV_LAST);
    assign h_wrap     = (pixel_x == H_LAST);
    assign line_end   = pixel_tick && h_wrap;
    assign frame_end  = line_end && (pixel_y == V_LAST);

    always_comb begin
        h_next = pixel_x;
        v_next = pixel_y;
        if (pixel_tick) begin
            if (h_wrap) begin
                h_next = '0;
                v_next = (pixel_y == V_LAST) ? '0 : pixel_y + 1'b1;
            end else begin
                h_next = pixel_x + 1'b1;
            end
        end
    end

    // Syncs and blanking decode the next-state counters so they land on the
    // same edge as pixel_x/pixel_y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div      <= '0;
            pixel_x  <= '0;
            pixel_y  <= '0;
            hsync    <= ~HS_POL;
            vsync    <= ~VS_POL;
            video_on <= 1'b0;
        end else if (enable) begin
            div      <= (div == DIV_LAST) ? '0 : div + 1'b1;
            pixel_x  <= h_next;
            pixel_y  <= v_next;
            hsync    <= (h_next >= HS_START && h_next <= HS_STOP) ? HS_POL : ~HS_POL;
            vsync    <= (v_next >= VS_START && v_next <= VS_STOP) ? VS_POL : ~VS_POL;
            video_on <= (h_next < H_ACT) && (v_next < V_ACT);
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-mode instance and a tiny custom-mode
// instance, both compared every clk against an arithmetic raster model.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_a, rst_b, en_a, en_b;
    logic       tick_a, hs_a, vs_a, vo_a, le_a, fe_a;
    logic [9:0] x_a, y_a;
    logic       tick_b, hs_b, vs_b, vo_b, le_b, fe_b;
    logic [3:0] x_b, y_b;

    int checks = 0;
    int errors = 0;
    int n_a = 0;
    int n_b = 0;
    int fe_cnt_b = 0;

    typedef struct {
        logic tick, hs, vs, vo, le, fe;
        int   x, y;
    } exp_t;

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a), .pixel_tick(tick_a),
        .hsync(hs_a), .vsync(vs_a), .video_on(vo_a), .pixel_x(x_a),
        .pixel_y(y_a), .line_end(le_a), .frame_end(fe_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(4)
    ) dut_b (
        .clk(clk), .reset(rst_b), .enable(en_b), .pixel_tick(tick_b),
        .hsync(hs_b), .vsync(vs_b), .video_on(vo_b), .pixel_x(x_b),
        .pixel_y(y_b), .line_end(le_b), .frame_end(fe_b)
    );

    // n = enabled clk edges since reset; everything follows from n by division.
    function automatic exp_t model(input int n, input bit en, input bit rst,
                                   input int d, input int ha, input int hf,
                                   input int hsw, input int hb, input int va,
                                   input int vf, input int vsw, input int vb,
                                   input bit hp, input bit vp);
        exp_t e;
        int ht, vt, p;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        p = n / d;
        e.x = p % ht;
        e.y = (p / ht) % vt;
        e.tick = en && !rst && (n % d == d - 1);
        e.hs = (e.x >= ha + hf && e.x < ha + hf + hsw) ? hp : !hp;
        e.vs = (e.y >= va + vf && e.y < va + vf + vsw) ? vp : !vp;
        e.vo = (n != 0) && (e.x < ha) && (e.y < va);
        e.le = e.tick && (e.x == ht - 1);
        e.fe = e.le && (e.y == vt - 1);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        exp_t ea, eb;
        ea = model(n_a, en_a, rst_a, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
        eb = model(n_b, en_b, rst_b, 1, 4, 1, 1, 1, 3, 1, 1, 1, 1'b1, 1'b1);
        chk("a_tick", tick_a, ea.tick);  chk("a_hsync", hs_a, ea.hs);
        chk("a_vsync", vs_a, ea.vs);     chk("a_video_on", vo_a, ea.vo);
        chk("a_x", x_a, ea.x);           chk("a_y", y_a, ea.y);
        chk("a_line_end", le_a, ea.le);  chk("a_frame_end", fe_a, ea.fe);
        chk("b_tick", tick_b, eb.tick);  chk("b_hsync", hs_b, eb.hs);
        chk("b_vsync", vs_b, eb.vs);     chk("b_video_on", vo_b, eb.vo);
        chk("b_x", x_b, eb.x);           chk("b_y", y_b, eb.y);
        chk("b_line_end", le_b, eb.le);  chk("b_frame_end", fe_b, eb.fe);
        if (fe_b === 1'b1) fe_cnt_b++;
    endtask

    // One clk: edge, then drive next inputs mid-cycle, then sample.
    task automatic cycle(input bit ea, input bit eb, input bit ra, input bit rb);
        @(posedge clk);
        if (rst_a) n_a = 0; else if (en_a) n_a++;
        if (rst_b) n_b = 0; else if (en_b) n_b++;
        #1;
        en_a = ea; en_b = eb; rst_a = ra; rst_b = rb;
        if (ra) n_a = 0;
        if (rb) n_b = 0;
        #1;
        check_all();
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic mid_reset(input bit ra, input bit rb);
        #1;
        if (ra) begin rst_a = 1'b1; n_a = 0; end
        if (rb) begin rst_b = 1'b1; n_b = 0; end
        #1;
        check_all();
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
        #1;
        check_all();
        chk("a_rst_hsync", hs_a, 1);
        chk("b_rst_hsync", hs_b, 0);
        cycle(1, 1, 1, 1);
        cycle(1, 1, 0, 0);

        // Custom mode: three full frames with enable held high.
        fe_cnt_b = 0;
        while (n_b < 159) cycle(1, 1, 0, 0);
        chk("b_frame_count", fe_cnt_b, 3);
        chk("b_sync_x", x_b, 5);
        chk("b_sync_y", y_b, 4);
        chk("b_hsync_active", hs_b, 1);
        chk("b_vsync_active", vs_b, 1);
        mid_reset(0, 1);
        chk("b_hsync_cleared", hs_b, 0);
        chk("b_vsync_cleared", vs_b, 0);
        cycle(1, 1, 0, 0);

        // Default mode: freeze for 37 clk at div=2, pixel_x=100.
        while (n_a < 401) cycle(1, $urandom_range(3, 0) != 0, 0, 0);
        for (int i = 0; i < 37; i++) cycle(0, $urandom_range(3, 0) != 0, 0, 0);
        chk("a_hold_x", x_a, 100);
        chk("a_hold_tick", tick_a, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        chk("a_resume_tick", tick_a, 1);

        // Randomised enable on both, occasional resets on the small instance.
        for (int i = 0; i < 8000; i++)
            cycle($urandom_range(9, 0) != 0, $urandom_range(3, 0) != 0,
                  0, $urandom_range(99, 0) == 0);

        mid_reset(1, 1);
        chk("a_reset_x", x_a, 0);
        cycle(1, 1, 0, 0);
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
